// File: rtl/multdiv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : multdiv_arb_pkg
// Brief  : Shared types and constants for the two-port multdiv arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package multdiv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MAX_WAIT_DEFAULT = 40;
    localparam int WAIT_CNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/multdiv_arb_grant.sv
`default_nettype none
// ============================================================================
// Module : multdiv_arb_grant
// Brief  : One-hot grant between two requesters; on a tie the port that was
//          not served last wins.
// Rev    : 1.0  initial release
// ============================================================================
module multdiv_arb_grant
    import multdiv_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_served,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last_served ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multdiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module : multdiv_arbiter
// Brief  : Shares one multdiv unit between two request ports with a WAIT
//          watchdog. Define MULTDIV_ARB_ROUND_ROBIN_EN for round-robin ties
//          (fixed priority to port 0 otherwise).
// Rev    : 1.0  initial release
// ============================================================================
module multdiv_arbiter
    import multdiv_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
)
(
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic        req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic        req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,

    output logic        rsp0_valid,
    output logic [31:0] rsp0_result,
    output logic        rsp0_exception,

    output logic        rsp1_valid,
    output logic [31:0] rsp1_result,
    output logic        rsp1_exception,

    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY
);

    // Counter reaching MAX_WAIT-1 is detected one increment early so the
    // response lands exactly MAX_WAIT cycles after the ctrl pulse.
    localparam logic [WAIT_CNT_W-1:0] c_wait_last = WAIT_CNT_W'(MAX_WAIT - 2);

    arb_state_t              r_state;
    arb_state_t              w_next_state;

    logic                    r_op;
    logic                    r_port;
    logic [31:0]             r_a;
    logic [31:0]             r_b;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [31:0]             r_rsp_result [2];
    logic                    r_rsp_exc    [2];

    logic [1:0]              w_grant;
    logic                    w_last_served;
    logic                    w_accept;
    logic                    w_timeout;

    multdiv_arb_grant u_grant (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_served (w_last_served),
        .grant       (w_grant)
    );

`ifdef MULTDIV_ARB_ROUND_ROBIN_EN
    logic r_last_served;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_served <= 1'b1;
        end else if (w_accept) begin
            r_last_served <= w_grant[1];
        end
    end

    assign w_last_served = r_last_served;
`else
    // Pretending port 1 was always last served makes port 0 win every tie.
    assign w_last_served = 1'b1;
`endif

    assign w_accept  = (r_state == ST_IDLE) && (w_grant != 2'b00);
    assign w_timeout = (r_wait_cnt == c_wait_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant != 2'b00) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  if (md_resultRDY || w_timeout) w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        req0_ready     = (r_state == ST_IDLE) && w_grant[0] && !reset;
        req1_ready     = (r_state == ST_IDLE) && w_grant[1] && !reset;
        md_ctrl_MULT   = (r_state == ST_ISSUE) && (r_op == OP_MULT);
        md_ctrl_DIV    = (r_state == ST_ISSUE) && (r_op == OP_DIV);
        rsp0_valid     = (r_state == ST_RESP) && !r_port;
        rsp1_valid     = (r_state == ST_RESP) && r_port;
        md_operandA    = r_a;
        md_operandB    = r_b;
        rsp0_result    = r_rsp_result[0];
        rsp0_exception = r_rsp_exc[0];
        rsp1_result    = r_rsp_result[1];
        rsp1_exception = r_rsp_exc[1];
    end

    // ------------------------------------------------------------------
    // Request latch, watchdog counter and per-port response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op            <= OP_MULT;
            r_port          <= 1'b0;
            r_a             <= '0;
            r_b             <= '0;
            r_wait_cnt      <= '0;
            r_rsp_result[0] <= '0;
            r_rsp_result[1] <= '0;
            r_rsp_exc[0]    <= 1'b0;
            r_rsp_exc[1]    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_port <= w_grant[1];
                        r_op   <= w_grant[1] ? req1_op : req0_op;
                        r_a    <= w_grant[1] ? req1_a  : req0_a;
                        r_b    <= w_grant[1] ? req1_b  : req0_b;
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (md_resultRDY) begin
                        r_rsp_result[r_port] <= md_result;
                        r_rsp_exc[r_port]    <= md_exception;
                    end else if (w_timeout) begin
                        r_rsp_result[r_port] <= '0;
                        r_rsp_exc[r_port]    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
